// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest FP-writeback collector.
package difftest_pkg;

  localparam int DEST_W   = 32;
  localparam int DATA_W   = 64;
  localparam int COREID_W = 8;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } fpwb_entry_t;

  // Ceiling log2, usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/difftest_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request found when scanning
// upward from ptr, wrapping modulo N. Purely combinational; the caller owns
// the pointer so that a grant which is not accepted persists.
module difftest_rr_arbiter
  import difftest_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // Rotating-priority scan: the first hit wins, later hits are ignored.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
      idx = (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/difftest_fpwb_arbiter.sv
// Collects FP writeback events from NUM_REQ ports through a round-robin
// arbiter into a FIFO, and drains one event per cycle to the difftest sink.
// Requesters are backpressured when the FIFO is full, so nothing is dropped.
module difftest_fpwb_arbiter
  import difftest_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16,
  parameter int DEST_W  = 32,
  parameter int DATA_W  = 64
) (
  input  logic                      io_clock,
  input  logic                      io_reset_n,
  input  logic [COREID_W-1:0]       io_coreid,
  input  logic                      io_flush,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  input  logic [NUM_REQ*DEST_W-1:0] io_req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_data,
  output logic [NUM_REQ-1:0]        io_req_ready,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [COREID_W-1:0]       io_out_coreid,
  output logic [DEST_W-1:0]         io_out_dest,
  output logic [DATA_W-1:0]         io_out_data,
  output logic [clog2(DEPTH+1)-1:0] io_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Storage is deliberately not reset; only pointers and count are.
  logic [DEST_W-1:0] mem_dest_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               deq_req;
  logic               can_enq;
  logic               enq;
  logic               deq;
  logic [DEST_W-1:0]  enq_dest;
  logic [DATA_W-1:0]  enq_data;

  difftest_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (io_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Handshakes: a full FIFO still accepts when the head leaves this cycle.
  // Reset and flush block both enqueue and dequeue.
  always_comb begin
    io_out_valid  = (count_q != '0);
    deq_req       = io_out_valid && io_out_ready;
    can_enq       = (count_q < CNT_W'(DEPTH)) || deq_req;
    enq           = grant_any && can_enq && !io_flush && io_reset_n;
    deq           = deq_req && !io_flush && io_reset_n;
    io_req_ready  = enq ? grant : '0;
    enq_dest      = io_req_dest[int'(grant_idx)*DEST_W +: DEST_W];
    enq_data      = io_req_data[int'(grant_idx)*DATA_W +: DATA_W];
    io_out_coreid = io_coreid;
    io_out_dest   = io_out_valid ? mem_dest_q[rd_ptr_q] : '0;
    io_out_data   = io_out_valid ? mem_data_q[rd_ptr_q] : '0;
    io_count      = count_q;
  end

  // Next pointers/count; flush clears everything, rr_ptr only moves on accept.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rr_ptr_d = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (!enq && deq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge io_clock) begin
    if (!io_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Write the accepted event at the tail.
  always_ff @(posedge io_clock) begin
    if (enq) begin
      mem_dest_q[wr_ptr_q] <= enq_dest;
      mem_data_q[wr_ptr_q] <= enq_data;
    end
  end

endmodule

// File: tb/tb_difftest_fpwb_arbiter.sv
// Scoreboard bench for difftest_fpwb_arbiter: the driver predicts accepts from
// a queue-based model and pushes expected events; the monitor pops and
// compares whenever the DUT hands an event to the sink.
module tb_difftest_fpwb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 16;
  localparam int DEST_W  = 32;
  localparam int DATA_W  = 64;

  logic                      io_clock = 1'b0;
  logic                      io_reset_n;
  logic [7:0]                io_coreid;
  logic                      io_flush;
  logic [NUM_REQ-1:0]        io_req_valid;
  logic [NUM_REQ*DEST_W-1:0] io_req_dest;
  logic [NUM_REQ*DATA_W-1:0] io_req_data;
  logic [NUM_REQ-1:0]        io_req_ready;
  logic                      io_out_valid;
  logic                      io_out_ready;
  logic [7:0]                io_out_coreid;
  logic [DEST_W-1:0]         io_out_dest;
  logic [DATA_W-1:0]         io_out_data;
  logic [4:0]                io_count;

  always #5 io_clock = ~io_clock;

  difftest_fpwb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DEPTH   (DEPTH),
    .DEST_W  (DEST_W),
    .DATA_W  (DATA_W)
  ) dut (
    .io_clock      (io_clock),
    .io_reset_n    (io_reset_n),
    .io_coreid     (io_coreid),
    .io_flush      (io_flush),
    .io_req_valid  (io_req_valid),
    .io_req_dest   (io_req_dest),
    .io_req_data   (io_req_data),
    .io_req_ready  (io_req_ready),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_coreid (io_out_coreid),
    .io_out_dest   (io_out_dest),
    .io_out_data   (io_out_data),
    .io_count      (io_count)
  );

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } ev_t;

  int  total = 0;
  int  bad   = 0;
  ev_t sb[$];
  int  m_rr  = 0;
  int  first_cycle = 1;

  logic              pend_v    [NUM_REQ];
  logic [DEST_W-1:0] pend_dest [NUM_REQ];
  logic [DATA_W-1:0] pend_data [NUM_REQ];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic any_pend();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) r = r | pend_v[i];
    return r;
  endfunction

  task automatic set_req(input int i, input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] x);
    pend_v[i]    = 1'b1;
    pend_dest[i] = d;
    pend_data[i] = x;
  endtask

  // One clock cycle: drive at negedge, predict and check, update the model.
  task automatic step();
    logic [NUM_REQ-1:0] exp_rdy;
    int pick;
    int occ;
    ev_t e;
    for (int i = 0; i < NUM_REQ; i++) begin
      io_req_valid[i]                   = pend_v[i];
      io_req_dest[i*DEST_W +: DEST_W]   = pend_dest[i];
      io_req_data[i*DATA_W +: DATA_W]   = pend_data[i];
    end
    #1;
    occ     = sb.size();
    exp_rdy = '0;
    pick    = -1;
    if (io_reset_n && !io_flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_rr + k) % NUM_REQ;
        if (pick < 0 && pend_v[j]) pick = j;
      end
      if (pick >= 0 && !(occ < DEPTH || (occ > 0 && io_out_ready))) pick = -1;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
    end
    chk("req_ready", 64'(io_req_ready), 64'(exp_rdy));
    chk("out_coreid", 64'(io_out_coreid), 64'(io_coreid));
    if (!first_cycle) begin
      chk("count", 64'(io_count), 64'(occ));
      chk("out_valid", 64'(io_out_valid), 64'(occ != 0));
      if (occ == 0) begin
        chk("empty_dest", 64'(io_out_dest), 64'd0);
        chk("empty_data", io_out_data, 64'd0);
      end
    end
    first_cycle = 0;
    if (!io_reset_n || io_flush) begin
      sb.delete();
      m_rr = 0;
    end else if (pick >= 0) begin
      e.dest = pend_dest[pick];
      e.data = pend_data[pick];
      sb.push_back(e);
      pend_v[pick] = 1'b0;
      m_rr = (pick + 1) % NUM_REQ;
    end
    @(posedge io_clock);
    @(negedge io_clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    io_out_ready = 1'b1;
    while ((sb.size() != 0 || any_pend()) && n < 80) begin
      step();
      n++;
    end
  endtask

  // Monitor: every dequeue handshake must match the oldest expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge io_clock);
      #2;
      if (io_reset_n && !io_flush && io_out_valid && io_out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(io_out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_dest", 64'(io_out_dest), 64'(e.dest));
          chk("out_data", io_out_data, e.data);
        end
      end
    end
  end

  initial begin
    int stream;
    int n;
    io_reset_n   = 1'b0;
    io_flush     = 1'b0;
    io_out_ready = 1'b0;
    io_coreid    = 8'h5a;
    io_req_valid = '0;
    io_req_dest  = '0;
    io_req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, DEST_W'(i), {$urandom(), $urandom()});
    @(negedge io_clock);

    // reset held with every requester valid
    for (int c = 0; c < 3; c++) step();
    chk("rst_count", 64'(io_count), 64'd0);
    chk("rst_valid", 64'(io_out_valid), 64'd0);
    io_reset_n = 1'b1;

    // round-robin with all requesters valid, dest = requester index
    io_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend_v[i]) set_req(i, DEST_W'(i), {$urandom(), $urandom()});
      step();
    end
    chk("rr_count", 64'(io_count), 64'd1);

    // fill to full from requester 2 with the sink stalled
    drain();
    io_out_ready = 1'b0;
    stream = 0;
    for (int c = 0; c < 18; c++) begin
      if (!pend_v[2] && stream < 17) begin
        set_req(2, DEST_W'(100 + stream), {$urandom(), $urandom()});
        stream++;
      end
      step();
    end
    chk("full_count", 64'(io_count), 64'd16);
    chk("full_ready2", 64'(io_req_ready[2]), 64'd0);

    // full with simultaneous dequeue and enqueue
    set_req(1, DEST_W'(200), {$urandom(), $urandom()});
    io_out_ready = 1'b1;
    step();
    chk("full_simul_count", 64'(io_count), 64'd16);
    drain();

    // flush with five events buffered and a request pending
    io_out_ready = 1'b0;
    n = 0;
    while (sb.size() < 5 && n < 100) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend_v[i] && $urandom_range(0, 1) == 1) set_req(i, $urandom(), {$urandom(), $urandom()});
      step();
      n++;
    end
    chk("preflush_count", 64'(io_count), 64'd5);
    if (!pend_v[2]) set_req(2, DEST_W'(300), {$urandom(), $urandom()});
    io_flush = 1'b1;
    step();
    io_flush = 1'b0;
    chk("flush_count", 64'(io_count), 64'd0);
    chk("flush_valid", 64'(io_out_valid), 64'd0);
    chk("flush_dest", 64'(io_out_dest), 64'd0);
    step();
    drain();

    // single sparse requester
    set_req(3, DEST_W'(7), 64'hDEAD_BEEF_0000_0001);
    step();
    chk("sparse_dest", 64'(io_out_dest), 64'd7);
    chk("sparse_data", io_out_data, 64'hDEAD_BEEF_0000_0001);
    step();
    chk("sparse_drop", 64'(io_out_valid), 64'd0);

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend_v[i] && $urandom_range(0, 99) < 40) set_req(i, $urandom(), {$urandom(), $urandom()});
      io_out_ready = ($urandom_range(0, 99) < 60);
      io_flush     = ($urandom_range(0, 199) == 0);
      io_reset_n   = ($urandom_range(0, 499) != 0);
      if (c % 7 == 0) io_coreid = 8'($urandom());
      step();
    end
    io_flush   = 1'b0;
    io_reset_n = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/difftest_fpwb_arbiter.md
Name: difftest_fpwb_arbiter

Overview:
- Collects FP register-file writeback events from several FP writeback ports and buffers them in a FIFO.
- Drains the FIFO one event per cycle into the single-port FP-writeback difftest sink.
- Sits between the FP execution-unit writeback buses and the difftest FP-writeback DPI bridge; simulation-only infrastructure.
- Backpressures requesters when the buffer is full, so no event is ever dropped.

Parameters:
- NUM_REQ, 4: number of writeback requesters, 2..8.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- DEST_W, 32: destination register index width.
- DATA_W, 64: writeback data width.

Ports:
- io_clock  in  1  clock; all state updates on rising edge.
- io_reset_n  in  1  synchronous, active-low reset.
- io_coreid  in  8  hart id; passed combinationally to io_out_coreid.
- io_flush  in  1  synchronous clear of FIFO and arbiter pointer.
- io_req_valid  in  NUM_REQ  per-requester event valid.
- io_req_dest  in  NUM_REQ*DEST_W  per-requester destination; requester i occupies slice [i*DEST_W +: DEST_W].
- io_req_data  in  NUM_REQ*DATA_W  per-requester data; same slicing rule.
- io_req_ready  out  NUM_REQ  per-requester accept.
- io_out_valid  out  1  FIFO head valid.
- io_out_ready  in  1  sink accept; tie to 1 for DPI.
- io_out_coreid  out  8  equals io_coreid.
- io_out_dest  out  DEST_W  head destination; 0 when empty.
- io_out_data  out  DATA_W  head data; 0 when empty.
- io_count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (io_reset_n=0 at a clock edge) and flush:
  - count=0, rd_ptr=wr_ptr=0, rr_ptr=0.
  - All outputs are 0 after the edge, except io_out_coreid.
  - Reset in mid-operation discards all buffered events.
  - io_flush has identical effect. It is ignored while in reset.
  - During a flush cycle io_req_ready=0 and no dequeue occurs.
- Arbitration is round-robin.
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first valid requester found is granted; at most one grant per cycle.
  - io_req_ready[i] = grant[i] && can_enq && !io_flush.
  - can_enq = (count<DEPTH) || (io_out_valid && io_out_ready). Enqueuing while full is allowed when a dequeue happens in the same cycle.
  - rr_ptr <= granted+1 (mod NUM_REQ) only when the accept fires. Otherwise rr_ptr holds, so a blocked grant persists until it is accepted.
  - Requesters must hold valid, dest and data stable until ready is asserted.
- Enqueue: on accept, write {dest,data} at wr_ptr; wr_ptr increments mod DEPTH.
- Dequeue:
  - io_out_valid = (count!=0).
  - Head fields are read combinationally from storage at rd_ptr and gated to 0 when empty.
  - On io_out_valid && io_out_ready, rd_ptr increments mod DEPTH.
- Count update per cycle:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on both or neither.
- Latency: an event accepted in cycle N is visible on io_out in cycle N+1 at the earliest. There is no bypass.
- Ordering:
  - Output order equals acceptance order.
  - Same-cycle conflicts are resolved only by the round-robin.
- Empty: dequeue is impossible. If io_out_ready=1 while empty, there is no effect.
- Full with io_out_ready=0: all io_req_ready=0.
- Storage array is not reset. Only pointers and count are reset.

Decomposition:
- Package difftest_pkg holds:
  - constants DEST_W, DATA_W, COREID_W=8;
  - typedef fpwb_entry_t {dest, data};
  - function clog2 helper if needed.
- One sub-module, difftest_rr_arbiter, parameterised on N. Its interface:
  - in: req[N], ptr;
  - out: grant one-hot, grant_idx, any.
- The FIFO stays inline.

Test Plan:
- Reset: hold io_reset_n=0 3 cycles with all io_req_valid=1 -> io_req_ready=0, io_out_valid=0, io_count=0; after release, first grant goes to requester 0.
- Round-robin: requesters 0..3 valid constantly, dest=i, io_out_ready=1 -> output dest sequence 0,1,2,3,0,1... one event per cycle; io_count stays 1 after the first cycle.
- Full backpressure: io_out_ready=0, requester 2 streams dest 100..115 -> after 16 accepts io_count=16 and ready[2]=0; raise io_out_ready -> dests 100..115 emerge in order, data intact.
- Full with simultaneous deq/enq: count=16, io_out_ready=1, requester 1 valid -> ready[1]=1 and io_count stays 16 that cycle.
- Flush mid-stream: count=5, assert io_flush 1 cycle -> next cycle io_count=0, io_out_valid=0, outputs 0; a request valid during the flush cycle is accepted only afterwards, with rr_ptr restarted at 0.
- Single sparse requester: only requester 3 valid, dest=7, data=0xDEAD_BEEF_0000_0001 -> io_out matches exactly one cycle after accept, then io_out_valid drops.
